// File: rtl/timer_regs.sv
// Wishbone classic register bank for the timer/PWM peripheral: CTRL, DIVISOR,
// PERIOD and duty-cycle registers, plus sticky irq status and the bus interrupt.
module timer_regs #(
  parameter int              DW         = 16,
  parameter int              AW         = 2,
  parameter logic [DW-1:0]   DIV_RST    = 16'd1,
  parameter logic [DW-1:0]   PERIOD_RST = 16'hFFFF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_adr,
  input  logic [DW-1:0] i_wb_dat,
  input  logic [1:0]    i_wb_sel,
  output logic [DW-1:0] o_wb_dat,
  output logic          o_wb_ack,
  input  logic          i_core_irq,
  output logic [7:0]    o_ctrl,
  output logic [DW-1:0] o_divisor,
  output logic [DW-1:0] o_period,
  output logic [DW-1:0] o_dc,
  output logic          o_timer_core_en,
  output logic          o_cont,
  output logic          o_irq_clear,
  output logic          o_irq
);

  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_DIV    = AW'(1);
  localparam logic [AW-1:0] A_PERIOD = AW'(2);
  localparam logic [AW-1:0] A_DC     = AW'(3);

  logic [6:0]    r_ctrl;      // bit5 is never stored; status lives in r_status
  logic          r_status;
  logic [DW-1:0] r_divisor;
  logic [DW-1:0] r_period;
  logic [DW-1:0] r_dc;
  logic          r_ack;
  logic [DW-1:0] r_rd_dat;
  logic          r_irq_clear;
  logic          r_irq;
  logic          r_core_irq_d;

  logic          w_req;
  logic          w_wr;
  logic          w_clr;
  logic          w_rise;
  logic [DW-1:0] w_div_merged;
  logic [DW-1:0] w_rd_mux;

  // Handshake: a request is cyc & stb while ack is low; ack follows on the next
  // edge for exactly one cycle, and writes commit / read data latches on that edge.
  assign w_req  = i_wb_cyc & i_wb_stb & ~r_ack;
  assign w_wr   = w_req & i_wb_we;
  assign w_clr  = w_wr & (i_wb_adr == A_CTRL) & i_wb_sel[0] & i_wb_dat[5];
  assign w_rise = i_core_irq & ~r_core_irq_d;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [1:0]    sel);
    logic [DW-1:0] m;
    m = old_v;
    if (sel[0]) m[7:0]    = new_v[7:0];
    if (sel[1]) m[DW-1:8] = new_v[DW-1:8];
    return m;
  endfunction

  assign w_div_merged = merge(r_divisor, i_wb_dat, i_wb_sel);

  always_comb begin
    w_rd_mux = '0;
    case (i_wb_adr)
      A_CTRL:   w_rd_mux = {{(DW-8){1'b0}}, r_status, r_ctrl};
      A_DIV:    w_rd_mux = r_divisor;
      A_PERIOD: w_rd_mux = r_period;
      A_DC:     w_rd_mux = r_dc;
      default:  w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl       <= '0;
      r_status     <= 1'b0;
      r_divisor    <= DIV_RST;
      r_period     <= PERIOD_RST;
      r_dc         <= '0;
      r_ack        <= 1'b0;
      r_rd_dat     <= '0;
      r_irq_clear  <= 1'b0;
      r_irq        <= 1'b0;
      r_core_irq_d <= 1'b0;
    end else begin
      r_ack        <= w_req;
      r_irq_clear  <= w_clr;
      r_irq        <= r_status & r_ctrl[6];
      r_core_irq_d <= i_core_irq;
      if (w_req && !i_wb_we) r_rd_dat <= w_rd_mux;
      if (w_wr) begin
        case (i_wb_adr)
          A_CTRL:   if (i_wb_sel[0]) r_ctrl <= {i_wb_dat[6], 1'b0, i_wb_dat[4:0]};
          A_DIV:    r_divisor <= (w_div_merged == '0) ? DW'(1) : w_div_merged;
          A_PERIOD: r_period  <= merge(r_period, i_wb_dat, i_wb_sel);
          A_DC:     r_dc      <= merge(r_dc, i_wb_dat, i_wb_sel);
          default:  ;
        endcase
      end
      // A new core irq edge beats a simultaneous clear so no event is lost.
      if (w_rise)     r_status <= 1'b1;
      else if (w_clr) r_status <= 1'b0;
    end
  end

  assign o_wb_ack        = r_ack;
  assign o_wb_dat        = r_rd_dat;
  assign o_ctrl          = {r_status, r_ctrl};
  assign o_divisor       = r_divisor;
  assign o_period        = r_period;
  assign o_dc            = r_dc;
  assign o_timer_core_en = ~r_ctrl[1] & r_ctrl[2];
  assign o_cont          = r_ctrl[3];
  assign o_irq_clear     = r_irq_clear;
  assign o_irq           = r_irq;

endmodule

// File: tb/tb_timer_regs.sv
// Self-checking bench for timer_regs: register map, byte lanes, irq path,
// back-to-back handshake and aborted/reset transactions.
module tb_timer_regs;

  logic        i_clk;
  logic        i_rst;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [1:0]  i_wb_adr;
  logic [15:0] i_wb_dat;
  logic [1:0]  i_wb_sel;
  logic [15:0] o_wb_dat;
  logic        o_wb_ack;
  logic        i_core_irq;
  logic [7:0]  o_ctrl;
  logic [15:0] o_divisor;
  logic [15:0] o_period;
  logic [15:0] o_dc;
  logic        o_timer_core_en;
  logic        o_cont;
  logic        o_irq_clear;
  logic        o_irq;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  logic [15:0] exp_q[$];

  timer_regs dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
    .i_core_irq(i_core_irq),
    .o_ctrl(o_ctrl), .o_divisor(o_divisor), .o_period(o_period), .o_dc(o_dc),
    .o_timer_core_en(o_timer_core_en), .o_cont(o_cont),
    .o_irq_clear(o_irq_clear), .o_irq(o_irq)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_irq_clear) clr_cnt++;

  task automatic idle_bus();
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  // driver: one bus transaction; reads pop their expectation from exp_q on ack
  task automatic bus_txn(input logic we, input logic [1:0] adr, input logic [15:0] dat,
                         input logic [1:0] sel, input bit irq_rise, input string name);
    bit got;
    logic [15:0] exp;
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
    if (irq_rise) i_core_irq = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge i_clk);
      if (o_wb_ack) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ack timeout got ack=%b required ack=1", name, o_wb_ack);
      if (!we && exp_q.size() > 0) exp = exp_q.pop_front();
    end else if (!we) begin
      exp = exp_q.pop_front();
      checks++;
      if (o_wb_dat !== exp) begin
        errors++;
        $display("FAIL %s rdata got %h required %h", name, o_wb_dat, exp);
      end
    end
    idle_bus();
    @(negedge i_clk);
    checks++;
    if (o_wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_width got ack=%b required 0", name, o_wb_ack);
    end
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [15:0] dat,
                          input logic [1:0] sel, input string name);
    bus_txn(1'b1, adr, dat, sel, 1'b0, name);
  endtask

  task automatic wb_read(input logic [1:0] adr, input logic [15:0] exp, input string name);
    exp_q.push_back(exp);
    bus_txn(1'b0, adr, 16'h0, 2'b11, 1'b0, name);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    wait_cycles(3);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_wb_ack, o_irq, o_irq_clear} !== 3'b000 || o_wb_dat !== 16'h0) begin
      errors++;
      $display("FAIL reset_outs got ack=%b irq=%b clr=%b dat=%h required 0",
               o_wb_ack, o_irq, o_irq_clear, o_wb_dat);
    end
    checks++;
    if (o_ctrl !== 8'h00 || o_divisor !== 16'h0001 || o_period !== 16'hFFFF || o_dc !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs got ctrl=%h div=%h per=%h dc=%h required 00 0001 ffff 0000",
               o_ctrl, o_divisor, o_period, o_dc);
    end
    wb_read(2'd0, 16'h0000, "rst_ctrl");
    wb_read(2'd1, 16'h0001, "rst_div");
    wb_read(2'd2, 16'hFFFF, "rst_period");
    wb_read(2'd3, 16'h0000, "rst_dc");
  endtask

  task automatic test_byte_lanes();
    logic [15:0] dc_model;
    logic [15:0] d;
    logic [1:0]  s;
    wb_write(2'd2, 16'h1234, 2'b01, "period_lo");
    wb_read(2'd2, 16'hFF34, "period_lo");
    wb_write(2'd1, 16'h0000, 2'b11, "div_zero");
    wb_read(2'd1, 16'h0001, "div_zero");
    wb_write(2'd1, 16'hA500, 2'b10, "div_hi");
    wb_read(2'd1, 16'hA501, "div_hi");
    dc_model = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      s = 2'($urandom_range(0, 3));
      wb_write(2'd3, d, s, "dc_rand");
      if (s[0]) dc_model[7:0]  = d[7:0];
      if (s[1]) dc_model[15:8] = d[15:8];
      wb_read(2'd3, dc_model, "dc_rand");
    end
  endtask

  task automatic test_ctrl();
    wb_write(2'd0, 16'h000C, 2'b01, "ctrl_0c");
    checks++;
    if (o_timer_core_en !== 1'b1 || o_cont !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_0c got en=%b cont=%b required 1 1", o_timer_core_en, o_cont);
    end
    wb_write(2'd0, 16'h000E, 2'b01, "ctrl_0e");
    checks++;
    if (o_timer_core_en !== 1'b0 || o_cont !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_0e got en=%b cont=%b required 0 1", o_timer_core_en, o_cont);
    end
    wb_write(2'd0, 16'h0000, 2'b10, "ctrl_nosel");
    wb_read(2'd0, 16'h000E, "ctrl_nosel");
    wb_write(2'd0, 16'hFFFF, 2'b11, "ctrl_ff");
    wb_read(2'd0, 16'h005F, "ctrl_ff");
  endtask

  task automatic test_irq();
    int c0;
    wb_write(2'd0, 16'h004C, 2'b01, "irq_en");
    @(negedge i_clk);
    i_core_irq = 1'b1;
    wait_cycles(3);
    checks++;
    if (o_irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_raise got o_irq=%b required 1", o_irq);
    end
    wb_read(2'd0, 16'h00CC, "irq_status");
    i_core_irq = 1'b0;
    wait_cycles(2);
    c0 = clr_cnt;
    wb_write(2'd0, 16'h006C, 2'b01, "irq_clear");
    wait_cycles(2);
    checks++;
    if (clr_cnt - c0 != 1) begin
      errors++;
      $display("FAIL irq_clear_pulse got %0d cycles required 1", clr_cnt - c0);
    end
    wb_read(2'd0, 16'h004C, "irq_cleared");
    checks++;
    if (o_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_drop got o_irq=%b required 0", o_irq);
    end
    // status captured even with irq enable off
    wb_write(2'd0, 16'h000C, 2'b01, "irq_dis");
    @(negedge i_clk);
    i_core_irq = 1'b1;
    wait_cycles(3);
    checks++;
    if (o_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked got o_irq=%b required 0", o_irq);
    end
    wb_read(2'd0, 16'h008C, "irq_masked_status");
    i_core_irq = 1'b0;
    wb_write(2'd0, 16'h006C, 2'b01, "irq_clear2");
    wb_read(2'd0, 16'h004C, "irq_cleared2");
  endtask

  task automatic test_set_wins();
    int c0;
    wait_cycles(2);
    c0 = clr_cnt;
    bus_txn(1'b1, 2'd0, 16'h006C, 2'b01, 1'b1, "set_wins");
    wait_cycles(2);
    checks++;
    if (clr_cnt - c0 != 1) begin
      errors++;
      $display("FAIL set_wins_pulse got %0d cycles required 1", clr_cnt - c0);
    end
    wb_read(2'd0, 16'h00CC, "set_wins_status");
    checks++;
    if (o_irq !== 1'b1) begin
      errors++;
      $display("FAIL set_wins_irq got o_irq=%b required 1", o_irq);
    end
    i_core_irq = 1'b0;
  endtask

  task automatic test_abort();
    int acks;
    // reset lands while a write is pending
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = 2'd2; i_wb_dat = 16'h5555; i_wb_sel = 2'b11;
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ack got ack=%b required 0", o_wb_ack);
    end
    i_rst = 1'b0;
    idle_bus();
    @(negedge i_clk);
    checks++;
    if (o_period !== 16'hFFFF || o_ctrl !== 8'h00 || o_divisor !== 16'h0001 || o_irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_regs got per=%h ctrl=%h div=%h irq=%b required ffff 00 0001 0",
               o_period, o_ctrl, o_divisor, o_irq);
    end
    // strobe dropped before any edge samples it, then cyc-only and stb-only cycles
    acks = 0;
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = 2'd3; i_wb_dat = 16'hABCD; i_wb_sel = 2'b11;
    #2 i_wb_stb = 1'b0;
    @(negedge i_clk); if (o_wb_ack) acks++;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b1;
    @(negedge i_clk); if (o_wb_ack) acks++;
    idle_bus();
    @(negedge i_clk); if (o_wb_ack) acks++;
    checks++;
    if (acks != 0 || o_dc !== 16'h0000) begin
      errors++;
      $display("FAIL abort got acks=%0d dc=%h required 0 0000", acks, o_dc);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    bit  prev;
    logic [15:0] exp;
    acks = 0;
    prev = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(16'hFFFF);
    @(negedge i_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
    i_wb_adr = 2'd2; i_wb_sel = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      if (o_wb_ack) begin
        acks++;
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL b2b_gap got ack on consecutive cycles required gap");
        end
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          checks++;
          if (o_wb_dat !== exp) begin
            errors++;
            $display("FAIL b2b_rdata got %h required %h", o_wb_dat, exp);
          end
        end
      end
      prev = o_wb_ack;
    end
    idle_bus();
    exp_q.delete();
    checks++;
    if (acks != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d acks required 3", acks);
    end
  endtask

  initial begin
    i_rst = 1'b0;
    i_core_irq = 1'b0;
    idle_bus();
    test_reset();
    test_byte_lanes();
    test_ctrl();
    test_irq();
    test_set_wins();
    test_abort();
    test_back_to_back();
    wait_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_regs.md
Name: timer_regs

Overview:
- Wishbone classic slave register bank for the timer/PWM peripheral.
- Sits directly upstream of the timer core and drives its control inputs:
  - continuous-mode bit
  - single-cycle irq-clear pulse
  - period register
  - core-enable term (~ctrl[1] & ctrl[2])
- Also holds divisor and duty-cycle registers for the clock divider and PWM path.
- Captures the core's irq level into a sticky status bit and drives the bus-level interrupt.

Parameters:
- DW, 16, data width of bus and timing registers
- AW, 2, word address width (4 registers)
- DIV_RST, 16'd1, reset value of DIVISOR
- PERIOD_RST, 16'hFFFF, reset value of PERIOD

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  bus cycle valid
- i_wb_stb  in  1  strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_adr  in  AW  word address
- i_wb_dat  in  DW  write data
- i_wb_sel  in  2  byte lanes; bit0 = [7:0], bit1 = [15:8]
- o_wb_dat  out  DW  read data, valid while o_wb_ack = 1
- o_wb_ack  out  1  one-cycle acknowledge
- i_core_irq  in  1  irq level from timer core (already in i_clk domain)
- o_ctrl  out  8  CTRL register contents
- o_divisor  out  DW  DIVISOR register
- o_period  out  DW  PERIOD register
- o_dc  out  DW  duty-cycle register
- o_timer_core_en  out  1  ~ctrl[1] & ctrl[2]
- o_cont  out  1  ctrl[3]
- o_irq_clear  out  1  one-cycle clear pulse to core
- o_irq  out  1  bus interrupt = status & ctrl[6]

Behaviour:
Reset and timing
- Reset is synchronous, active-high; clock is the single i_clk.
- Values on reset:
  - CTRL = 0
  - DIVISOR = DIV_RST
  - PERIOD = PERIOD_RST
  - DC = 0
  - status = 0
  - o_wb_ack = 0
  - o_wb_dat = 0
  - o_irq_clear = 0
  - o_irq = 0
- Reset asserted mid-transaction: ack is suppressed; any pending write is lost.

Register map (word address)
- 0 = CTRL, bits [7:0]:
  - bit0 external-clock select
  - bit1 mode, 1 = PWM
  - bit2 enable
  - bit3 continuous
  - bit4 PWM output enable
  - bit5 irq clear; write-1 action, always reads 0
  - bit6 irq enable
  - bit7 status; read-only, write ignored
  - Upper bits read 0.
- 1 = DIVISOR. A written value of 0 is stored as 1.
- 2 = PERIOD.
- 3 = DC.

Handshake
- A request is i_wb_cyc & i_wb_stb & !o_wb_ack.
- o_wb_ack rises on the edge after the request and stays high for exactly one cycle.
- Back-to-back requests are therefore acked every other cycle at most.
- Writes commit on the same edge that raises ack, honouring i_wb_sel per byte lane.
- Read data is registered on the same edge and is held in o_wb_dat for the ack cycle.
- If cyc/stb drop before ack, no ack is generated and no register changes.

Irq path
- Rising edge of i_core_irq (registered previous-value compare) sets status.
- A CTRL write with bit5 = 1 and sel[0] = 1:
  - clears status
  - pulses o_irq_clear for exactly one cycle, on the cycle after the write commits
  - the stored bit5 stays 0
- Rising edge in the same cycle as a clear: set wins, status stays 1.
- o_irq is registered: status & ctrl[6].
- Status is still captured when ctrl[6] = 0.

Derived outputs
- o_timer_core_en and o_cont are combinational from the CTRL flop.
- A new CTRL value is visible the cycle after ack rises.

Test Plan:
1. Reset, then read all 4 addresses -> 0x0000, 0x0001, 0xFFFF, 0x0000; each ack exactly 1 cycle wide.
2. Write PERIOD = 0x1234 with sel = 2'b01, then read -> 0xFF34. Write DIVISOR = 0 -> reads 0x0001.
3. Write CTRL = 0x0C -> o_timer_core_en = 1, o_cont = 1. Write CTRL = 0x0E -> o_timer_core_en = 0.
4. Raise i_core_irq with ctrl[6] = 1 -> status reads 1 in CTRL bit7 and o_irq = 1. Write CTRL = 0x6C -> o_irq_clear high exactly one cycle, status = 0, CTRL reads 0x4C.
5. i_core_irq rising edge in the same cycle as the clear write commits -> status = 1 and o_irq_clear still pulses once.
6. Assert i_rst while stb is held with no ack yet -> no ack, registers back to reset values. Drop stb before ack -> no write occurs.
